// File: rtl/jsq_sched_pkg.sv
// Shared definitions for the jsq_sched start scheduler: FSM state encoding and
// the width of the gap / watchdog counters.
package jsq_sched_pkg;

   localparam int JSQ_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FIRE    = 3'd1,
      ST_WAIT_HI = 3'd2,
      ST_WAIT_LO = 3'd3,
      ST_GAP     = 3'd4
   } jsq_state_t;

endpackage

// File: rtl/jsq_sched_rr_arb.sv
// Combinational round-robin pick for jsq_sched: the first pending requester
// found when searching upward from ptr+1 (mod N_REQ).
module jsq_sched_rr_arb #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] pending,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             any_valid
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      cand      = '0;
      // Scan from the farthest slot back to ptr+1 so the nearest hit is written last.
      for (int k = N_REQ; k >= 1; k--) begin
         cand = IDX_W'((int'(ptr) + k) % N_REQ);
         if (pending[cand]) begin
            winner    = cand;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/jsq_sched.sv
// Round-robin start scheduler for the shared one-shot pulse counter.
// Optional watchdog on the dout wait states is enabled by defining JSQ_SCHED_TMO_EN.
module jsq_sched
   import jsq_sched_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int GAP_CYC = 2,
   parameter int TMO_CYC = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic                     dout_in,
   output logic                     en_out,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [N_REQ-1:0]         ovf
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CW1   = JSQ_CNT_W + 1;
   localparam logic [CW1-1:0] GAP_LIM = CW1'(GAP_CYC);

   jsq_state_t           state;
   logic [IDX_W-1:0]     ptr;
   logic [N_REQ-1:0]     pending;
   logic [JSQ_CNT_W-1:0] gap_cnt;
   logic [IDX_W-1:0]     winner;
   logic                 any_valid;
   logic [N_REQ-1:0]     grant_mask;
   logic                 gap_last;

   jsq_sched_rr_arb #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .pending   (pending),
      .ptr       (ptr),
      .winner    (winner),
      .any_valid (any_valid)
   );

   assign grant_mask = (state == ST_IDLE && any_valid) ? (N_REQ'(1) << winner) : '0;

   // GAP always lasts at least one cycle so the done pulse has somewhere to live.
   assign gap_last = (CW1'(gap_cnt) + CW1'(1)) >= GAP_LIM;

`ifdef JSQ_SCHED_TMO_EN
   localparam logic [CW1-1:0] TMO_LIM = CW1'(TMO_CYC);
   logic [JSQ_CNT_W-1:0] wd_cnt;
   logic                 wd_hit;
   logic [JSQ_CNT_W-1:0] wd_inc;

   assign wd_hit = (CW1'(wd_cnt) + CW1'(1)) >= TMO_LIM;
   assign wd_inc = (wd_cnt == '1) ? wd_cnt : wd_cnt + JSQ_CNT_W'(1);
`else
   // Watchdog limit has no effect when the waits are unbounded.
   logic tmo_unused;
   assign tmo_unused = ^TMO_CYC;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         pending  <= '0;
         ovf      <= '0;
         gap_cnt  <= '0;
         en_out   <= 1'b0;
         grant_id <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
`ifdef JSQ_SCHED_TMO_EN
         wd_cnt   <= '0;
`endif
      end else begin
         en_out  <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         // A request landing on the grant cycle of the same requester is kept as new work.
         pending <= (pending & ~grant_mask) | req;
         ovf     <= ovf | (req & pending & ~grant_mask);

         if (state == ST_GAP) begin
            if (gap_cnt != '1) gap_cnt <= gap_cnt + JSQ_CNT_W'(1);
         end else begin
            gap_cnt <= '0;
         end
`ifdef JSQ_SCHED_TMO_EN
         wd_cnt <= '0;
`endif

         case (state)
            ST_IDLE: begin
               if (any_valid) begin
                  state    <= ST_FIRE;
                  en_out   <= 1'b1;
                  busy     <= 1'b1;
                  grant_id <= winner;
                  ptr      <= winner;
               end
            end
            ST_FIRE: state <= ST_WAIT_HI;
            ST_WAIT_HI: begin
               if (dout_in) begin
                  state <= ST_WAIT_LO;
               end
`ifdef JSQ_SCHED_TMO_EN
               else if (wd_hit) begin
                  state <= ST_GAP;
                  err   <= 1'b1;
               end else begin
                  wd_cnt <= wd_inc;
               end
`endif
            end
            ST_WAIT_LO: begin
               if (!dout_in) begin
                  state <= ST_GAP;
                  done  <= 1'b1;
               end
`ifdef JSQ_SCHED_TMO_EN
               else if (wd_hit) begin
                  state <= ST_GAP;
                  err   <= 1'b1;
               end else begin
                  wd_cnt <= wd_inc;
               end
`endif
            end
            ST_GAP: begin
               if (gap_last) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
